// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences each instruction through fetch/decode/execute/memory/writeback.
// Optional mult/div and mfhi/mflo support is enabled by defining MC_CTRL_MULDIV_EN.
module mc_ctrl #(
    parameter int ALUCTR_W = 5,
    parameter int MEM_WAIT = 0,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         Instr,
    input  logic                zero,
    output logic                PCWr,
    output logic                IRWr,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic [1:0]          RegDst,
    output logic                ALUSrc,
    output logic [1:0]          MemtoReg,
    output logic [3:0]          nPC_sel,
    output logic [1:0]          ExtOp,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                md_start,
    output logic [1:0]          md_op,
    output logic                hilo_sel,
    output logic                illegal,
    output logic                instr_done,
    output logic [2:0]          state
);

    // state  | meaning
    // FETCH  | load IR, PC <= PC+4
    // DECODE | resolve jumps, route everything else
    // EXE    | ALU operand/operation select, mult/div launch
    // MEM    | sw write, or lw read with MEM_WAIT extra cycles
    // WB     | register file write
    // BR     | beq compare, conditional PC write
    // MD     | wait out the mult/div latency
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_MD     = 3'd6,
        S_BAD    = 3'd7
    } state_t;

`ifdef MC_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [3:0] MEM_LOAD  = 4'(MEM_WAIT);
    localparam logic [4:0] MULT_LOAD = 5'(MULT_LAT - 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_LAT - 1);

    state_t     cur, nxt;
    logic [3:0] mem_cnt;
    logic [4:0] md_cnt;

    logic [5:0] opcode, funct;
    logic is_rtype, is_addu, is_subu, is_jr, is_j, is_jal, is_beq;
    logic is_addi, is_ori, is_lui, is_lw, is_sw;
    logic is_muldiv, is_div, is_mfhi, is_mflo, to_exe;
    logic unused_instr;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];

    assign is_rtype  = (opcode == 6'h00);
    assign is_addu   = is_rtype && (funct == 6'h21);
    assign is_subu   = is_rtype && (funct == 6'h23);
    assign is_jr     = is_rtype && (funct == 6'h08) && (Instr[20:11] == 10'd0);
    assign is_j      = (opcode == 6'h02);
    assign is_jal    = (opcode == 6'h03);
    assign is_beq    = (opcode == 6'h04);
    assign is_addi   = (opcode == 6'h08);
    assign is_ori    = (opcode == 6'h0D);
    assign is_lui    = (opcode == 6'h0F);
    assign is_lw     = (opcode == 6'h23);
    assign is_sw     = (opcode == 6'h2B);
    // funct 0110xx covers mult, multu, div, divu; bit 1 selects divide
    assign is_muldiv = MD_EN && is_rtype && (funct[5:2] == 4'b0110);
    assign is_div    = funct[1];
    assign is_mfhi   = MD_EN && is_rtype && (funct == 6'h10);
    assign is_mflo   = MD_EN && is_rtype && (funct == 6'h12);
    assign to_exe    = is_addu || is_subu || is_addi || is_ori || is_lui ||
                       is_lw || is_sw || is_muldiv || is_mfhi || is_mflo;

    assign unused_instr = ^{Instr[25:21], Instr[10:6]};

    assign state = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= S_FETCH;
            mem_cnt <= 4'd0;
            md_cnt  <= 5'd0;
        end else begin
            cur <= nxt;
            if (cur == S_EXE && nxt == S_MEM)
                mem_cnt <= is_lw ? MEM_LOAD : 4'd0;
            else if (cur == S_MEM && mem_cnt != 4'd0)
                mem_cnt <= mem_cnt - 4'd1;
            if (cur == S_EXE && nxt == S_MD)
                md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
            else if (cur == S_MD && md_cnt != 5'd0)
                md_cnt <= md_cnt - 5'd1;
        end
    end

    always_comb begin
        nxt        = S_FETCH;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 2'b00;
        ALUSrc     = 1'b0;
        MemtoReg   = 2'b00;
        nPC_sel    = 4'd0;
        ExtOp      = 2'b00;
        ALUctr     = '0;
        md_start   = 1'b0;
        md_op      = 2'b00;
        hilo_sel   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        // outputs are forced quiet for as long as reset is held
        if (reset_n) begin
            case (cur)
                S_FETCH: begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    nPC_sel = 4'd0;
                    nxt     = S_DECODE;
                end
                S_DECODE: begin
                    if (is_j || is_jal) begin
                        PCWr       = 1'b1;
                        nPC_sel    = 4'd2;
                        instr_done = 1'b1;
                        if (is_jal) begin
                            RegWrite = 1'b1;
                            RegDst   = 2'b10;
                            MemtoReg = 2'b10;
                        end
                    end else if (is_jr) begin
                        PCWr       = 1'b1;
                        nPC_sel    = 4'd3;
                        instr_done = 1'b1;
                    end else if (is_beq) begin
                        nxt = S_BR;
                    end else if (to_exe) begin
                        nxt = S_EXE;
                    end else begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXE: begin
                    if (is_subu)
                        ALUctr = ALUCTR_W'(1);
                    if (is_addi || is_lw || is_sw || is_lui)
                        ALUSrc = 1'b1;
                    if (is_ori) begin
                        ALUSrc = 1'b1;
                        ExtOp  = 2'b01;
                        ALUctr = ALUCTR_W'(2);
                    end
                    if (is_lui)
                        ExtOp = 2'b10;
                    if (is_lw || is_sw) begin
                        nxt = S_MEM;
                    end else if (is_muldiv) begin
                        md_start = 1'b1;
                        md_op    = funct[1:0];
                        nxt      = S_MD;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_MEM: begin
                    if (is_sw) begin
                        MemWrite   = 1'b1;
                        instr_done = 1'b1;
                    end else if (mem_cnt != 4'd0) begin
                        nxt = S_MEM;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    RegDst     = is_rtype ? 2'b01 : 2'b00;
                    if (is_lw)
                        MemtoReg = 2'b01;
                    else if (is_mfhi || is_mflo)
                        MemtoReg = 2'b11;
                    hilo_sel = is_mfhi;
                end
                S_BR: begin
                    nPC_sel    = 4'd1;
                    PCWr       = zero;
                    ALUctr     = ALUCTR_W'(1);
                    instr_done = 1'b1;
                end
                S_MD: begin
                    if (md_cnt == 5'd0)
                        instr_done = 1'b1;
                    else
                        nxt = S_MD;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed cases plus random instruction stream against a per-instruction trace model.
module tb_mc_ctrl;

    localparam int ALUCTR_W = 5;
    localparam int MEM_WAIT = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

`ifdef MC_CTRL_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef enum int {
        K_ADDU, K_SUBU, K_ADDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL,
        K_JR, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_BADOP, K_BADFN, K_BADJR
    } kind_t;

    typedef struct packed {
        logic                pcwr;
        logic                irwr;
        logic                regwrite;
        logic                memwrite;
        logic [1:0]          regdst;
        logic                alusrc;
        logic [1:0]          memtoreg;
        logic [3:0]          npc;
        logic [1:0]          extop;
        logic [ALUCTR_W-1:0] aluctr;
        logic                md_start;
        logic [1:0]          md_op;
        logic                hilo_sel;
        logic                illegal;
        logic                instr_done;
        logic [2:0]          st;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] Instr = 32'h00221821;

    logic                PCWr, IRWr, RegWrite, MemWrite, ALUSrc;
    logic [1:0]          RegDst, MemtoReg, ExtOp, md_op;
    logic [3:0]          nPC_sel;
    logic [ALUCTR_W-1:0] ALUctr;
    logic                md_start, hilo_sel, illegal, instr_done;
    logic [2:0]          state;

    mc_ctrl #(
        .ALUCTR_W(ALUCTR_W),
        .MEM_WAIT(MEM_WAIT),
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Instr     (Instr),
        .zero      (zero),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .MemtoReg  (MemtoReg),
        .nPC_sel   (nPC_sel),
        .ExtOp     (ExtOp),
        .ALUctr    (ALUctr),
        .md_start  (md_start),
        .md_op     (md_op),
        .hilo_sel  (hilo_sel),
        .illegal   (illegal),
        .instr_done(instr_done),
        .state     (state)
    );

    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = {PCWr, IRWr, RegWrite, MemWrite, RegDst, ALUSrc, MemtoReg, nPC_sel,
                  ExtOp, ALUctr, md_start, md_op, hilo_sel, illegal, instr_done, state};

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];

    task automatic check(input string tag, input ctl_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Random encoding of an instruction of the given kind.
    function automatic logic [31:0] encode(input kind_t k);
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [9:0]  junk;
        logic [5:0]  op;
        logic [31:0] w;
        rs   = 5'($urandom());
        rt   = 5'($urandom());
        rd   = 5'($urandom());
        sh   = 5'($urandom());
        imm  = 16'($urandom());
        tgt  = 26'($urandom());
        junk = 10'($urandom_range(1, 1023));
        w    = 32'd0;
        case (k)
            K_ADDU:  w = {6'h00, rs, rt, rd, sh, 6'h21};
            K_SUBU:  w = {6'h00, rs, rt, rd, sh, 6'h23};
            K_ADDI:  w = {6'h08, rs, rt, imm};
            K_ORI:   w = {6'h0D, rs, rt, imm};
            K_LUI:   w = {6'h0F, rs, rt, imm};
            K_LW:    w = {6'h23, rs, rt, imm};
            K_SW:    w = {6'h2B, rs, rt, imm};
            K_BEQ:   w = {6'h04, rs, rt, imm};
            K_J:     w = {6'h02, tgt};
            K_JAL:   w = {6'h03, tgt};
            K_JR:    w = {6'h00, rs, 10'd0, sh, 6'h08};
            K_MULT:  w = {6'h00, rs, rt, rd, sh, 6'h18};
            K_MULTU: w = {6'h00, rs, rt, rd, sh, 6'h19};
            K_DIV:   w = {6'h00, rs, rt, rd, sh, 6'h1A};
            K_DIVU:  w = {6'h00, rs, rt, rd, sh, 6'h1B};
            K_MFHI:  w = {6'h00, rs, rt, rd, sh, 6'h10};
            K_MFLO:  w = {6'h00, rs, rt, rd, sh, 6'h12};
            K_BADOP: begin
                case ($urandom_range(0, 4))
                    0: op = 6'h01;
                    1: op = 6'h05;
                    2: op = 6'h20;
                    3: op = 6'h2A;
                    default: op = 6'h3F;
                endcase
                w = {op, tgt};
            end
            K_BADFN: begin
                case ($urandom_range(0, 4))
                    0: op = 6'h20;
                    1: op = 6'h22;
                    2: op = 6'h24;
                    3: op = 6'h25;
                    default: op = 6'h00;
                endcase
                w = {6'h00, rs, rt, rd, sh, op};
            end
            default: w = {6'h00, rs, junk, sh, 6'h08};
        endcase
        return w;
    endfunction

    // Expected cycle-by-cycle outputs for one instruction, from FETCH to its last cycle.
    function automatic void build(input kind_t k, input logic z);
        ctl_t c;
        bit   md_k, hl_k, alu_k, rtyp;
        int   lat;
        md_k  = (k == K_MULT || k == K_MULTU || k == K_DIV || k == K_DIVU);
        hl_k  = (k == K_MFHI || k == K_MFLO);
        alu_k = (k == K_ADDU || k == K_SUBU || k == K_ADDI || k == K_ORI ||
                 k == K_LUI || k == K_LW || k == K_SW) || (MD && (md_k || hl_k));
        rtyp  = (k == K_ADDU || k == K_SUBU || md_k || hl_k);
        exp_q.delete();

        c = '0; c.pcwr = 1'b1; c.irwr = 1'b1; c.st = 3'd0;
        exp_q.push_back(c);

        c = '0; c.st = 3'd1;
        if (k == K_J || k == K_JAL || k == K_JR) begin
            c.pcwr = 1'b1;
            c.npc = (k == K_JR) ? 4'd3 : 4'd2;
            c.instr_done = 1'b1;
            if (k == K_JAL) begin
                c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
            end
            exp_q.push_back(c);
        end else if (k == K_BEQ) begin
            exp_q.push_back(c);
            c = '0; c.st = 3'd5; c.npc = 4'd1; c.pcwr = z; c.aluctr = 1; c.instr_done = 1'b1;
            exp_q.push_back(c);
        end else if (alu_k) begin
            exp_q.push_back(c);
            c = '0; c.st = 3'd2;
            case (k)
                K_SUBU:             c.aluctr = 1;
                K_ADDI, K_LW, K_SW: c.alusrc = 1'b1;
                K_ORI:  begin c.alusrc = 1'b1; c.extop = 2'b01; c.aluctr = 2; end
                K_LUI:  begin c.alusrc = 1'b1; c.extop = 2'b10; end
                default: ;
            endcase
            if (md_k) begin
                c.md_start = 1'b1;
                c.md_op = {(k == K_DIV || k == K_DIVU), (k == K_MULTU || k == K_DIVU)};
            end
            exp_q.push_back(c);
            if (k == K_SW) begin
                c = '0; c.st = 3'd3; c.memwrite = 1'b1; c.instr_done = 1'b1;
                exp_q.push_back(c);
            end else if (md_k) begin
                lat = (k == K_DIV || k == K_DIVU) ? DIV_LAT : MULT_LAT;
                for (int i = 0; i < lat; i++) begin
                    c = '0; c.st = 3'd6; c.instr_done = (i == lat - 1);
                    exp_q.push_back(c);
                end
            end else begin
                if (k == K_LW) begin
                    for (int i = 0; i <= MEM_WAIT; i++) begin
                        c = '0; c.st = 3'd3;
                        exp_q.push_back(c);
                    end
                end
                c = '0; c.st = 3'd4; c.regwrite = 1'b1; c.instr_done = 1'b1;
                c.regdst   = rtyp ? 2'b01 : 2'b00;
                c.memtoreg = (k == K_LW) ? 2'b01 : (hl_k ? 2'b11 : 2'b00);
                c.hilo_sel = (k == K_MFHI);
                exp_q.push_back(c);
            end
        end else begin
            c.illegal = 1'b1; c.instr_done = 1'b1;
            exp_q.push_back(c);
        end
    endfunction

    // Called just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input kind_t k, input logic [31:0] w, input logic z, input string name);
        build(k, z);
        Instr = w;
        zero  = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s %h step%0d", name, w, i), exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        kind_t       k;
        logic [31:0] w;
        logic        z;

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), ctl_t'('0));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_instr(K_ADDU, 32'h00221821, 1'b0, "addu");
        run_instr(K_LW,   32'h8C050004, 1'b0, "lw");
        run_instr(K_BEQ,  32'h10220003, 1'b0, "beq_nt");
        run_instr(K_BEQ,  32'h10220003, 1'b1, "beq_t");
        run_instr(K_JAL,  32'h0C000010, 1'b0, "jal");
        run_instr(K_SW,   32'hAC050004, 1'b0, "sw");
        run_instr(K_ORI,  32'h3423FFFF, 1'b0, "ori");
        run_instr(K_LUI,  32'h3C031234, 1'b0, "lui");
        run_instr(K_JR,   32'h03E00008, 1'b0, "jr");
        run_instr(K_BADOP, 32'hFC000000, 1'b0, "illegal");
        run_instr(K_DIV,  32'h0022001A, 1'b0, "div");

        // lw interrupted by reset in its second MEM cycle
        build(K_LW, 1'b0);
        Instr = 32'h8C050004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("lw_abort step%0d", i), exp_q[i]);
            @(posedge clk);
            #1;
        end
        check("lw_abort in_mem", exp_q[4]);
        #2;
        reset_n = 1'b0;
        #1;
        check("lw_abort async", ctl_t'('0));
        @(negedge clk);
        check("lw_abort held", ctl_t'('0));
        @(posedge clk);
        #1;
        check("lw_abort edge", ctl_t'('0));
        reset_n = 1'b1;
        run_instr(K_ADDI, 32'h2003FFFF, 1'b0, "addi_after_rst");

        for (int n = 0; n < 250; n++) begin
            k = kind_t'($urandom_range(0, 19));
            w = encode(k);
            z = 1'($urandom());
            run_instr(k, w, z, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
